vector_pair_loader: RTL and testbench

Streaming front end for `vector_multiplier`. It accepts one element pair (a, b) per handshake and packs VECTOR_SIZE pairs into the multiplier's flat operand buses. It then pulses `trigger`, waits a fixed number of cycles, captures `dot_product`, and presents it on a valid/ready output. It replaces bench-side bulk vector preloading with a synthesizable initiator for the multiplier.

---
 rtl/vector_pkg.sv | 17 +
 rtl/vector_pair_loader_check.sv | 49 ++++
 rtl/vector_pair_loader.sv | 126 ++++++++++++
 tb/tb_vector_pair_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared definitions for vector_multiplier and its streaming loader.
//   loader_state_t        - loader FSM states (LOAD, FIRE, WAIT, HOLD)
//   DEFAULT_ELEMENT_SIZE  - default element / product / dot-product width
//   DEFAULT_VECTOR_SIZE   - default number of elements per vector
package vector_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } loader_state_t;

    localparam int DEFAULT_ELEMENT_SIZE = 16;
    localparam int DEFAULT_VECTOR_SIZE  = 20;

endpackage

// File: rtl/vector_pair_loader_check.sv
// vector_pair_loader_check: reference dot-product accumulator and comparator.
//   clk, rst      - clock, asynchronous active-high reset
//   clear         - restart the accumulator for the next vector pair
//   add_en        - accept in_a*in_b into the running sum
//   in_a, in_b    - element pair being loaded
//   capture       - multiplier result is sampled this cycle
//   dot_product   - multiplier result to compare against
//   mismatch      - result of the most recent comparison
//   error_count   - saturating count of mismatching captures
module vector_pair_loader_check #(
    parameter int ELEMENT_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add_en,
    input  logic [ELEMENT_SIZE-1:0] in_a,
    input  logic [ELEMENT_SIZE-1:0] in_b,
    input  logic                    capture,
    input  logic [ELEMENT_SIZE-1:0] dot_product,
    output logic                    mismatch,
    output logic [15:0]             error_count
);

    logic [ELEMENT_SIZE-1:0] acc;
    logic [ELEMENT_SIZE-1:0] product;

    // Products and the sum both wrap at the element width, like the multiplier.
    assign product = ELEMENT_SIZE'(in_a * in_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            mismatch    <= 1'b0;
            error_count <= '0;
        end else begin
            if (clear)
                acc <= '0;
            else if (add_en)
                acc <= acc + product;
            if (capture) begin
                mismatch <= (acc != dot_product);
                if (acc != dot_product && error_count != 16'hFFFF)
                    error_count <= error_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/vector_pair_loader.sv
// vector_pair_loader: streams element pairs into packed operand buses for
// vector_multiplier, triggers it, waits, and returns the dot product on a
// valid/ready output.
//   clk, rst                   - clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b - element pair input handshake
//   mul_trigger                - one-cycle start pulse to the multiplier
//   mul_vector_a/mul_vector_b  - packed operand buses (element 0 in LSBs)
//   mul_dot_product            - multiplier result
//   out_valid/out_ready        - result output handshake
//   out_dot_product            - captured dot product
//   out_pair_count             - completed pairs, modulo 2^16
//   out_mismatch, error_count  - self-check results
// Optional self-check: define VECTOR_PAIR_LOADER_CHECK_EN; otherwise
// out_mismatch and error_count are tied to zero.
module vector_pair_loader
    import vector_pkg::*;
#(
    parameter int ELEMENT_SIZE = DEFAULT_ELEMENT_SIZE,
    parameter int VECTOR_SIZE  = DEFAULT_VECTOR_SIZE,
    parameter int RESULT_WAIT  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ELEMENT_SIZE-1:0]             in_a,
    input  logic [ELEMENT_SIZE-1:0]             in_b,
    output logic                                mul_trigger,
    output logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] mul_vector_a,
    output logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] mul_vector_b,
    input  logic [ELEMENT_SIZE-1:0]             mul_dot_product,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ELEMENT_SIZE-1:0]             out_dot_product,
    output logic [15:0]                         out_pair_count,
    output logic                                out_mismatch,
    output logic [15:0]                         error_count
);

    localparam int IDX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESULT_WAIT - 1);

    loader_state_t     state, next_state;
    logic [IDX_W-1:0]  elem_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_hs;
    logic              capture;
    logic              out_hs;

    assign in_hs   = in_valid && in_ready;
    assign capture = (state == WAIT) && (wait_cnt == '0);
    assign out_hs  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= next_state;
    end

    // Handshake outputs decode registered state only, so out_ready never
    // reaches in_ready combinationally.
    always_comb begin
        next_state  = state;
        in_ready    = (state == LOAD);
        mul_trigger = (state == FIRE);
        out_valid   = (state == HOLD);
        case (state)
            LOAD:    if (in_valid && elem_idx == LAST_IDX) next_state = FIRE;
            FIRE:    next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = HOLD;
            HOLD:    if (out_ready) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_idx        <= '0;
            wait_cnt        <= '0;
            mul_vector_a    <= '0;
            mul_vector_b    <= '0;
            out_dot_product <= '0;
            out_pair_count  <= '0;
        end else begin
            if (in_hs) begin
                mul_vector_a[elem_idx*ELEMENT_SIZE +: ELEMENT_SIZE] <= in_a;
                mul_vector_b[elem_idx*ELEMENT_SIZE +: ELEMENT_SIZE] <= in_b;
                elem_idx <= (elem_idx == LAST_IDX) ? '0 : elem_idx + 1'b1;
            end
            if (state == FIRE)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (capture)
                out_dot_product <= mul_dot_product;
            if (out_hs)
                out_pair_count <= out_pair_count + 16'd1;
        end
    end

`ifdef VECTOR_PAIR_LOADER_CHECK_EN
    // The accumulator restarts on the return to LOAD, after its value has
    // been compared at capture.
    vector_pair_loader_check #(
        .ELEMENT_SIZE(ELEMENT_SIZE)
    ) u_check (
        .clk        (clk),
        .rst        (rst),
        .clear      (out_hs),
        .add_en     (in_hs),
        .in_a       (in_a),
        .in_b       (in_b),
        .capture    (capture),
        .dot_product(mul_dot_product),
        .mismatch   (out_mismatch),
        .error_count(error_count)
    );
`else
    assign out_mismatch = 1'b0;
    assign error_count  = '0;
`endif

endmodule

// File: tb/tb_vector_pair_loader.sv
// tb_vector_pair_loader: table-driven self-checking bench for vector_pair_loader.
module tb_vector_pair_loader;

    localparam int E  = 16;
    localparam int VS = 4;
    localparam int RW = 1;
`ifdef VECTOR_PAIR_LOADER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct packed {
        logic [VS-1:0][E-1:0] a;
        logic [VS-1:0][E-1:0] b;
        logic                 gap;
        logic [E-1:0]         bias;
        logic [3:0]           hold;
        logic [E-1:0]         dot;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [E-1:0]      in_a = '0;
    logic [E-1:0]      in_b = '0;
    logic              mul_trigger;
    logic [E*VS-1:0]   mul_vector_a;
    logic [E*VS-1:0]   mul_vector_b;
    logic [E-1:0]      mul_dot_product = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [E-1:0]      out_dot_product;
    logic [15:0]       out_pair_count;
    logic              out_mismatch;
    logic [15:0]       error_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_pc  = '0;
    logic [15:0] exp_err = '0;
    logic [E-1:0] bias = '0;

    always #5 clk = ~clk;

    vector_pair_loader #(
        .ELEMENT_SIZE(E),
        .VECTOR_SIZE (VS),
        .RESULT_WAIT (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mul_trigger    (mul_trigger),
        .mul_vector_a   (mul_vector_a),
        .mul_vector_b   (mul_vector_b),
        .mul_dot_product(mul_dot_product),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_dot_product(out_dot_product),
        .out_pair_count (out_pair_count),
        .out_mismatch   (out_mismatch),
        .error_count    (error_count)
    );

    // Behavioral multiplier: registers the wrapped dot product on trigger,
    // plus an optional bias to provoke a mismatch.
    function automatic logic [E-1:0] dot_of(input logic [E*VS-1:0] va, input logic [E*VS-1:0] vb);
        logic [E-1:0] s;
        s = '0;
        for (int i = 0; i < VS; i++)
            s = s + E'(va[i*E +: E] * vb[i*E +: E]);
        return s;
    endfunction

    always @(posedge clk)
        if (mul_trigger)
            mul_dot_product <= dot_of(mul_vector_a, mul_vector_b) + bias;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [VS-1:0][E-1:0] a, input logic [VS-1:0][E-1:0] b,
                                input logic gap, input logic [E-1:0] bs, input logic [3:0] hold,
                                input logic [E-1:0] dot);
        vec_t v;
        v.a = a; v.b = b; v.gap = gap; v.bias = bs; v.hold = hold; v.dot = dot;
        return v;
    endfunction

    task automatic send(input vec_t v, input int n);
        bit hs;
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a = v.a[i];
            in_b = v.b[i];
            guard = 0;
            do begin
                hs = in_ready;
                step();
                guard++;
            end while (!hs && guard < 20);
            if (!hs) chk("in_handshake_timeout", 0, 1);
            in_valid = 1'b0;
            if (v.gap && i < n - 1) begin
                step();
                step();
            end
        end
    endtask

    task automatic run_pair(input vec_t v);
        int lat, trig, trig_at;
        logic exp_mis;
        bias = v.bias;
        send(v, VS);
        lat = 1; trig = 0; trig_at = 0;
        while (lat < 10) begin
            if (mul_trigger) begin
                trig++;
                trig_at = lat;
            end
            if (out_valid) break;
            step();
            lat++;
        end
        chk("out_valid_latency", lat, 3);
        chk("trigger_count", trig, 1);
        chk("trigger_cycle", trig_at, 1);
        chk("vector_a", mul_vector_a, v.a);
        chk("vector_b", mul_vector_b, v.b);
        exp_mis = CHECK && (v.bias != '0);
        if (exp_mis && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        for (int h = 0; h < int'(v.hold); h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_dot", out_dot_product, v.dot);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_trigger", mul_trigger, 0);
            step();
        end
        chk("dot_product", out_dot_product, v.dot);
        chk("mismatch", out_mismatch, exp_mis);
        chk("error_count", error_count, exp_err);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_pc = exp_pc + 16'd1;
        chk("in_ready_after_out", in_ready, 1);
        chk("out_valid_after_out", out_valid, 0);
        chk("pair_count", out_pair_count, exp_pc);
    endtask

    vec_t tbl[5];
    vec_t v9;

    initial begin
        tbl[0] = mk({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 16'd0, 4'd0, 16'd70);
        tbl[1] = mk({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 16'd0, 4'd5, 16'd70);
        tbl[2] = mk({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 16'd0, 4'd0, 16'd70);
        tbl[3] = mk({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0, 16'd0, 4'd0, 16'd4);
        tbl[4] = mk({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 16'd1, 4'd0, 16'd71);
        v9     = mk({4{16'd9}}, {4{16'd1}}, 1'b0, 16'd0, 4'd0, 16'd36);

        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_trigger", mul_trigger, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        step();
        step();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_trigger", mul_trigger, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_vector_a", mul_vector_a, 0);
        chk("idle_vector_b", mul_vector_b, 0);
        chk("idle_dot", out_dot_product, 0);
        chk("idle_pair_count", out_pair_count, 0);
        chk("idle_mismatch", out_mismatch, 0);
        chk("idle_error_count", error_count, 0);

        for (int t = 0; t < 5; t++) run_pair(tbl[t]);
        chk("basic_vector_a_const", {48'd0, 16'd0} | tbl[0].a, 64'h0004_0003_0002_0001);

        bias = '0;
        send(tbl[0], VS);
        step();
        rst = 1'b1;
        #1;
        chk("midwait_rst_trigger", mul_trigger, 0);
        chk("midwait_rst_out_valid", out_valid, 0);
        chk("midwait_rst_in_ready", in_ready, 1);
        chk("midwait_rst_vector_a", mul_vector_a, 0);
        chk("midwait_rst_pair_count", out_pair_count, 0);
        chk("midwait_rst_error_count", error_count, 0);
        step();
        rst = 1'b0;
        exp_pc = '0;
        exp_err = '0;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_trigger", mul_trigger, 0);
            chk("post_rst_out_valid", out_valid, 0);
            step();
        end

        send(mk({4{16'd7}}, {4{16'd7}}, 1'b0, 16'd0, 4'd0, 16'd0), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        run_pair(v9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
